// File: rtl/stream_compare_sequencer.sv
// Sequencer for an external stream comparator: clear, settle, run a word window, latch, evaluate.
// Optional RUN-state timeout counter is built only when STREAM_COMPARE_SEQ_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start; done pulses here after a run ends
// CLEAR  | one-cycle cmp_reset pulse
// SETTLE | wait max(settle_cycles,1) cycles
// RUN    | cmp_trigger high until the word window is reached (or timeout)
// LATCH  | cmp_latch pulse, capture comparator counts
// EVAL   | compute pass, pulse done
module stream_compare_sequencer #(
    parameter int CNT_WIDTH    = 32,
    parameter int SETTLE_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CNT_WIDTH-1:0]    window_len,
    input  logic [CNT_WIDTH-1:0]    err_threshold,
    input  logic [SETTLE_WIDTH-1:0] settle_cycles,
    input  logic [CNT_WIDTH-1:0]    timeout_cycles,
    input  logic [CNT_WIDTH-1:0]    word_count,
    input  logic [CNT_WIDTH-1:0]    err_count,
    output logic                    cmp_reset,
    output logic                    cmp_latch,
    output logic                    cmp_trigger,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    aborted,
    output logic                    timed_out,
    output logic [CNT_WIDTH-1:0]    result_words,
    output logic [CNT_WIDTH-1:0]    result_errs
);

    typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, RUN, LATCH, EVAL} state_t;

    state_t                  state, state_nxt;
    logic [CNT_WIDTH-1:0]    cfg_window, cfg_thresh;
    logic [SETTLE_WIDTH-1:0] cfg_settle, settle_cnt;
    logic                    start_ok, abort_ok, settle_tc, window_hit, timeout_hit;

    // done is high during the first IDLE cycle, so a start there is refused
    assign start_ok   = (state == IDLE) && start && !done;
    assign abort_ok   = (state != IDLE) && abort;
    assign settle_tc  = (settle_cnt == SETTLE_WIDTH'(1));
    assign window_hit = (word_count >= cfg_window);

`ifdef STREAM_COMPARE_SEQ_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] cfg_timeout, run_cnt;
    logic                 timed_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_timeout <= '0;
            run_cnt     <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if (start_ok) begin
                cfg_timeout <= timeout_cycles;
                timed_out_q <= 1'b0;
            end else if ((state == RUN) && !abort_ok && timeout_hit) begin
                timed_out_q <= 1'b1;
            end
            if (state == CLEAR)
                run_cnt <= cfg_timeout;
            else if ((state == RUN) && (run_cnt != '0))
                run_cnt <= run_cnt - CNT_WIDTH'(1);
        end
    end

    assign timeout_hit = (cfg_timeout != '0) && (run_cnt == CNT_WIDTH'(1));
    assign timed_out   = timed_out_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cycles;
    assign timeout_hit    = 1'b0;
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cfg_window   <= '0;
            cfg_thresh   <= '0;
            cfg_settle   <= '0;
            settle_cnt   <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            aborted      <= 1'b0;
            result_words <= '0;
            result_errs  <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (start_ok) begin
                cfg_window <= window_len;
                cfg_thresh <= err_threshold;
                cfg_settle <= settle_cycles;
                pass       <= 1'b0;
                aborted    <= 1'b0;
            end
            if (state == CLEAR)
                settle_cnt <= (cfg_settle == '0) ? SETTLE_WIDTH'(1) : cfg_settle;
            else if (state == SETTLE)
                settle_cnt <= settle_cnt - SETTLE_WIDTH'(1);
            // abort wins over capture and evaluation in the same cycle
            if (abort_ok) begin
                done    <= 1'b1;
                aborted <= 1'b1;
                pass    <= 1'b0;
            end else if (state == LATCH) begin
                result_words <= word_count;
                result_errs  <= err_count;
            end else if (state == EVAL) begin
                pass <= (result_errs <= cfg_thresh) && !timed_out;
                done <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cmp_reset   = 1'b0;
        cmp_latch   = 1'b0;
        cmp_trigger = 1'b0;
        busy        = (state != IDLE);
        unique case (state)
            IDLE:   if (start_ok) state_nxt = CLEAR;
            CLEAR: begin
                cmp_reset = 1'b1;
                state_nxt = SETTLE;
            end
            SETTLE: if (settle_tc) state_nxt = RUN;
            RUN: begin
                cmp_trigger = 1'b1;
                if (timeout_hit || window_hit) state_nxt = LATCH;
            end
            LATCH: begin
                cmp_latch = !abort;
                state_nxt = EVAL;
            end
            EVAL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_ok) state_nxt = IDLE;
    end

endmodule

// File: doc/stream_compare_sequencer.md
STREAM_COMPARE_SEQUENCER -- requirements
Module: stream_compare_sequencer

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, setting the width of the word/error counters and thresholds.
REQ-002 SHALL have parameter SETTLE_WIDTH, default 8, setting the width of the settle-cycle count.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a comparison run; sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  terminate the active run.
REQ-007 SHALL have port window_len  input  CNT_WIDTH  number of compared words per run.
REQ-008 SHALL have port err_threshold  input  CNT_WIDTH  maximum error count that still passes.
REQ-009 SHALL have port settle_cycles  input  SETTLE_WIDTH  wait after comparator clear.
REQ-010 SHALL have port timeout_cycles  input  CNT_WIDTH  RUN-state cycle limit; 0 = disabled; used only with the macro.
REQ-011 SHALL have port word_count  input  CNT_WIDTH  live comparator word counter.
REQ-012 SHALL have port err_count  input  CNT_WIDTH  live comparator error counter.
REQ-013 SHALL have port cmp_reset  output  1  one-cycle comparator clear pulse.
REQ-014 SHALL have port cmp_latch  output  1  one-cycle comparator count-latch pulse.
REQ-015 SHALL have port cmp_trigger  output  1  mismatch-trigger enable to the comparator, high in RUN only.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle run-complete pulse.
REQ-018 SHALL have port pass, aborted, timed_out  output  1 each  run status, held until the next accepted start.
REQ-019 SHALL have port result_words, result_errs  output  CNT_WIDTH each  counts captured at latch.

Function
REQ-020 SHALL implement the states IDLE, CLEAR, SETTLE, RUN, LATCH, EVAL.
REQ-021 In IDLE, start=1 SHALL register window_len, err_threshold, settle_cycles and timeout_cycles, clear pass/aborted/timed_out, and move to CLEAR next cycle.
REQ-022 CLEAR SHALL assert cmp_reset for exactly one cycle, then go to SETTLE.
REQ-023 SETTLE SHALL last max(settle_cycles,1) cycles, then go to RUN.
REQ-024 RUN SHALL assert cmp_trigger and go to LATCH in the cycle after word_count >= window_len is first observed; window_len=0 exits after one RUN cycle.
REQ-025 LATCH SHALL assert cmp_latch for one cycle, capture word_count/err_count into result_words/result_errs, and go to EVAL.
REQ-026 EVAL SHALL set pass = (result_errs <= err_threshold) && !timed_out, pulse done for one cycle, and return to IDLE.
REQ-027 Comparisons SHALL be unsigned, full CNT_WIDTH; counter wrap-around from the comparator is not compensated.
REQ-028 abort=1 in any non-IDLE state SHALL go to IDLE next cycle, pulse done, set aborted=1 and pass=0, and leave the result registers unchanged.
REQ-029 Abort SHALL take priority over every other transition in the same cycle, including the timeout.
REQ-030 start while busy SHALL be ignored; abort in IDLE SHALL be ignored.
REQ-031 start asserted in the same cycle as done SHALL be ignored; the next run requires start while in IDLE.
REQ-032 Configuration inputs SHALL be ignored after capture until the next accepted start.

Reset
REQ-033 reset=1 SHALL force IDLE on the next clock edge and zero every output and register, including results and status.
REQ-034 reset during a run SHALL produce no done pulse and no cmp_latch pulse.

Configuration
REQ-035 With STREAM_COMPARE_SEQ_TIMEOUT_EN defined, a RUN-cycle counter SHALL run; on reaching a nonzero timeout_cycles the block SHALL set timed_out=1 and go to LATCH, so pass=0.
REQ-036 Without STREAM_COMPARE_SEQ_TIMEOUT_EN, the block SHALL contain no timeout counter, timeout_cycles SHALL be ignored, and timed_out SHALL be tied 0.

Verification
REQ-037 Scenario: window_len=100, settle_cycles=4, 3 errors injected, err_threshold=5 -> one cmp_reset, RUN exits at word_count=100, result_errs=3, pass=1, one done.
REQ-038 Scenario: same stimulus with err_threshold=2 -> pass=0, aborted=0, result_errs=3.
REQ-039 Scenario: abort in the 10th RUN cycle -> IDLE next cycle, done=1, aborted=1, pass=0, no cmp_latch pulse.
REQ-040 Scenario (macro defined): timeout_cycles=50, word_count stuck at 7 -> LATCH after 50 RUN cycles, timed_out=1, result_words=7, pass=0.
REQ-041 Scenario: start pulsed during SETTLE and in the done cycle -> exactly one run and one done.
REQ-042 Scenario: reset in RUN -> all outputs 0 next cycle, no done pulse; settle_cycles=0 -> SETTLE lasts 1 cycle.
